key_press_multi: RTL and testbench

- Parametrised, multi-channel key-event detector: N_KEYS independent channels.
- Each channel: SYNC_STAGES-flop synchroniser, DEBOUNCE-cycle stability filter, debounced level output, registered one-cycle event pulse.
- Runtime mode selects the event: release edge, press edge, press with auto-repeat, or both edges.
- Sits between raw board keys and game/control FSMs; replaces the single-key, unsynchronised, combinational-output release detector.

---
 rtl/key_press_pkg.sv | 30 +++
 rtl/key_press_channel.sv | 181 ++++++++++++++++++
 rtl/key_press_multi.sv | 35 +++
 tb/tb_key_press_multi.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/key_press_pkg.sv
// Shared types and helpers for the multi-channel key-event detector.
package key_press_pkg;

  // Event-selection mode, common to every channel.
  typedef enum logic [1:0] {
    MODE_RELEASE = 2'b00,
    MODE_PRESS   = 2'b01,
    MODE_REPEAT  = 2'b10,
    MODE_BOTH    = 2'b11
  } mode_t;

  // Per-channel debounce FSM states.
  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    PRESS_WAIT   = 2'b01,
    HELD         = 2'b10,
    RELEASE_WAIT = 2'b11
  } kp_state_t;

  // Width wide enough for the debounce and both repeat counters.
  function automatic int kp_cnt_width(input int debounce,
                                      input int repeat_delay,
                                      input int repeat_period);
    int m;
    m = (debounce > repeat_delay) ? debounce : repeat_delay;
    m = (m > repeat_period) ? m : repeat_period;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/key_press_channel.sv
// One key channel: synchroniser, debounce FSM, auto-repeat timer and
// registered held/pulse outputs.
module key_press_channel
  import key_press_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int DEBOUNCE      = 3,
  parameter int REPEAT_DELAY  = 8,
  parameter int REPEAT_PERIOD = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       key,
  input  logic [1:0] mode,
  output logic       pulse,
  output logic       held
);

  localparam int CW = kp_cnt_width(DEBOUNCE, REPEAT_DELAY, REPEAT_PERIOD);
  localparam logic [CW-1:0] ZERO    = CW'(0);
  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE - 1);
  localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_s;
  kp_state_t              state_r, state_s;
  logic [CW-1:0]          cnt_r, cnt_s;
  logic [CW-1:0]          rcnt_r, rcnt_s;
  logic                   rphase_r, rphase_s;
  logic                   press_ev_s, release_ev_s, repeat_ev_s;
  logic                   pulse_s, held_s;
  logic                   pulse_r, held_r;

  assign sync_s = sync_r[SYNC_STAGES-1];
  assign pulse  = pulse_r;
  assign held   = held_r;

  // Shift the raw key through the synchroniser chain.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], key};
    end
  end

  // State, debounce counter, repeat timer and output registers.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r  <= IDLE;
      cnt_r    <= ZERO;
      rcnt_r   <= ZERO;
      rphase_r <= 1'b0;
      pulse_r  <= 1'b0;
      held_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      rcnt_r   <= rcnt_s;
      rphase_r <= rphase_s;
      pulse_r  <= pulse_s;
      held_r   <= held_s;
    end
  end

  // Debounce next-state: a level must persist DEBOUNCE samples to be accepted.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    press_ev_s   = 1'b0;
    release_ev_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (sync_s) begin
          if (DEBOUNCE == 1) begin
            state_s    = HELD;
            cnt_s      = ZERO;
            press_ev_s = 1'b1;
          end else begin
            state_s = PRESS_WAIT;
            cnt_s   = ONE;
          end
        end else begin
          cnt_s = ZERO;
        end
      end
      PRESS_WAIT: begin
        if (!sync_s) begin
          state_s = IDLE;
          cnt_s   = ZERO;
        end else if (cnt_r == DB_LAST) begin
          state_s    = HELD;
          cnt_s      = ZERO;
          press_ev_s = 1'b1;
        end else begin
          cnt_s = cnt_r + ONE;
        end
      end
      HELD: begin
        if (!sync_s) begin
          if (DEBOUNCE == 1) begin
            state_s      = IDLE;
            cnt_s        = ZERO;
            release_ev_s = 1'b1;
          end else begin
            state_s = RELEASE_WAIT;
            cnt_s   = ONE;
          end
        end else begin
          cnt_s = ZERO;
        end
      end
      RELEASE_WAIT: begin
        if (sync_s) begin
          // Bounce back to pressed: no event, repeat timer keeps its phase.
          state_s = HELD;
          cnt_s   = ZERO;
        end else if (cnt_r == DB_LAST) begin
          state_s      = IDLE;
          cnt_s        = ZERO;
          release_ev_s = 1'b1;
        end else begin
          cnt_s = cnt_r + ONE;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = ZERO;
      end
    endcase
  end

  // Auto-repeat timer: first phase waits REPEAT_DELAY, then REPEAT_PERIOD
  // cycles per repeat. The counter reloads on each target so it never wraps.
  always_comb begin
    rcnt_s      = rcnt_r;
    rphase_s    = rphase_r;
    repeat_ev_s = 1'b0;
    if (press_ev_s) begin
      rcnt_s   = ZERO;
      rphase_s = 1'b0;
    end else if ((state_r == HELD || state_r == RELEASE_WAIT) &&
                 (state_s == HELD || state_s == RELEASE_WAIT)) begin
      if (!rphase_r) begin
        if (rcnt_r >= RD_LAST) begin
          repeat_ev_s = 1'b1;
          rcnt_s      = ZERO;
          rphase_s    = 1'b1;
        end else begin
          rcnt_s = rcnt_r + ONE;
        end
      end else begin
        if (rcnt_r >= RP_LAST) begin
          repeat_ev_s = 1'b1;
          rcnt_s      = ZERO;
        end else begin
          rcnt_s = rcnt_r + ONE;
        end
      end
    end else begin
      rcnt_s   = ZERO;
      rphase_s = 1'b0;
    end
  end

  // Output decode: the current mode selects which events become a pulse.
  always_comb begin
    held_s  = (state_s == HELD) || (state_s == RELEASE_WAIT);
    pulse_s = 1'b0;
    case (mode)
      MODE_RELEASE: pulse_s = release_ev_s;
      MODE_PRESS:   pulse_s = press_ev_s;
      MODE_REPEAT:  pulse_s = press_ev_s | repeat_ev_s;
      MODE_BOTH:    pulse_s = press_ev_s | release_ev_s;
      default:      pulse_s = 1'b0;
    endcase
  end

endmodule

// File: rtl/key_press_multi.sv
// N_KEYS independent key-event channels sharing clock, reset and mode.
module key_press_multi
  import key_press_pkg::*;
#(
  parameter int N_KEYS        = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int DEBOUNCE      = 3,
  parameter int REPEAT_DELAY  = 8,
  parameter int REPEAT_PERIOD = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [N_KEYS-1:0] key,
  input  logic [1:0]        mode,
  output logic [N_KEYS-1:0] pulse,
  output logic [N_KEYS-1:0] held
);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_press_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .DEBOUNCE     (DEBOUNCE),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .Clock(Clock),
      .Reset(Reset),
      .key  (key[i]),
      .mode (mode),
      .pulse(pulse[i]),
      .held (held[i])
    );
  end

endmodule

// File: tb/tb_key_press_multi.sv
// Scoreboard bench for key_press_multi: stimulus pushes expected pulses,
// a negedge monitor pops and compares them as the DUT pulses.
module tb_key_press_multi;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [3:0] key;
  logic [1:0] mode;
  logic [3:0] pulse;
  logic [3:0] held;

  typedef struct {
    int         cyc;
    logic [3:0] vec;
  } exp_t;

  exp_t exp_q[$];
  int   cyc_r = 0;
  int   total = 0;
  int   bad   = 0;

  always #5 Clock = ~Clock;

  key_press_multi #(
    .N_KEYS(4), .SYNC_STAGES(2), .DEBOUNCE(3), .REPEAT_DELAY(8), .REPEAT_PERIOD(4)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .key  (key),
    .mode (mode),
    .pulse(pulse),
    .held (held)
  );

  // Count rising edges so expectations can be stated in cycles.
  always @(posedge Clock) cyc_r <= cyc_r + 1;

  // Monitor: every pulse must match the head of the expected queue.
  always @(negedge Clock) begin
    if (cyc_r >= 1) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc_r) begin
        total++;
        bad++;
        $display("FAIL missed_pulse: cycle %0d got none want pulse=%b", exp_q[0].cyc, exp_q[0].vec);
        void'(exp_q.pop_front());
      end
      if (pulse !== 4'b0000) begin
        total++;
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc_r) begin
          if (pulse !== exp_q[0].vec) begin
            bad++;
            $display("FAIL pulse_vec: cycle %0d got %b want %b", cyc_r, pulse, exp_q[0].vec);
          end
          void'(exp_q.pop_front());
        end else begin
          bad++;
          $display("FAIL unexpected_pulse: cycle %0d got %b want 0000", cyc_r, pulse);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: cycle %0d got %b want %b", name, cyc_r, act, exp);
    end
  endtask

  task automatic expect_pulse(input int c, input logic [3:0] v);
    exp_q.push_back('{cyc: c, vec: v});
  endtask

  initial begin
    int c;
    Reset = 1'b1;
    key   = 4'hF;
    mode  = 2'b01;

    // Reset with all keys pressed, then release reset.
    tick(1);
    check("rst_held_1", held, 4'h0);
    check("rst_pulse_1", pulse, 4'h0);
    tick(1);
    check("rst_held_2", held, 4'h0);
    check("rst_pulse_2", pulse, 4'h0);
    Reset = 1'b0;
    c = cyc_r;
    expect_pulse(c + 5, 4'hF);
    tick(4);
    check("rst_held_early", held, 4'h0);
    tick(1);
    check("rst_held_rise", held, 4'hF);
    key = 4'h0;
    tick(5);
    check("rst_held_fall", held, 4'h0);
    tick(3);

    // Press edge on key 0; release must not pulse.
    mode = 2'b01;
    c = cyc_r;
    key = 4'b0001;
    expect_pulse(c + 5, 4'b0001);
    tick(4);
    check("press_held_early", held, 4'b0000);
    tick(1);
    check("press_held_rise", held, 4'b0001);
    tick(5);
    key = 4'b0000;
    tick(5);
    check("press_held_fall", held, 4'b0000);
    tick(3);

    // Release mode: 2-cycle glitch is filtered, then a real press/release.
    mode = 2'b00;
    key = 4'b0010;
    tick(2);
    key = 4'b0000;
    tick(8);
    check("glitch_held", held, 4'b0000);
    key = 4'b0010;
    tick(5);
    check("rel_held_rise", held, 4'b0010);
    tick(1);
    key = 4'b0000;
    c = cyc_r;
    expect_pulse(c + 5, 4'b0010);
    tick(4);
    check("rel_held_still", held, 4'b0010);
    tick(1);
    check("rel_held_fall", held, 4'b0000);
    tick(3);

    // Auto-repeat on key 2 held 25 cycles.
    mode = 2'b10;
    c = cyc_r;
    key = 4'b0100;
    expect_pulse(c + 5, 4'b0100);
    expect_pulse(c + 13, 4'b0100);
    expect_pulse(c + 17, 4'b0100);
    expect_pulse(c + 21, 4'b0100);
    expect_pulse(c + 25, 4'b0100);
    expect_pulse(c + 29, 4'b0100);
    tick(25);
    key = 4'b0000;
    tick(4);
    check("rep_held_still", held, 4'b0100);
    tick(1);
    check("rep_held_fall", held, 4'b0000);
    tick(8);

    // Both edges on keys 0 and 3 together.
    mode = 2'b11;
    c = cyc_r;
    key = 4'b1001;
    expect_pulse(c + 5, 4'b1001);
    tick(10);
    key = 4'b0000;
    expect_pulse(cyc_r + 5, 4'b1001);
    tick(5);
    check("both_held_fall", held, 4'b0000);
    tick(3);

    // Reset in the middle of an auto-repeat hold.
    mode = 2'b10;
    c = cyc_r;
    key = 4'b0100;
    expect_pulse(c + 5, 4'b0100);
    tick(10);
    Reset = 1'b1;
    tick(1);
    check("midrst_held", held, 4'b0000);
    check("midrst_pulse", pulse, 4'b0000);
    Reset = 1'b0;
    expect_pulse(cyc_r + 5, 4'b0100);
    tick(4);
    check("midrst_held_early", held, 4'b0000);
    tick(1);
    check("midrst_held_rise", held, 4'b0100);
    tick(1);
    key = 4'b0000;
    tick(5);
    check("midrst_held_fall", held, 4'b0000);
    tick(6);

    // Every expected pulse must have been consumed.
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL leftover_expect: got %0d pending want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
